pkt_egress_tx: RTL and testbench

PKT_EGRESS_TX -- requirements
Module: pkt_egress_tx

---
 rtl/pkt_egress_tx_if.sv | 48 ++++
 rtl/pkt_egress_tx.sv | 106 ++++++++++
 tb/tb_pkt_egress_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_egress_tx_if.sv
// Scheduler, descriptor/payload read and egress stream signals of the packet egress transmitter.
// Handshake: a tx word transfers on a rising clk edge where tx_valid && tx_ready; once raised, tx_valid and tx_data/tx_last/tx_prior hold until that edge.
interface pkt_egress_tx_if #(
  parameter int DWIDTH      = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int PRIOR_WIDTH = 6
);
  logic                   sche_valid;
  logic [DWIDTH-1:0]      sche_data;
  logic [PRIOR_WIDTH-1:0] sche_prior;
  logic                   sche_deque_en;

  logic                   desc_rd_en;
  logic [DWIDTH-1:0]      desc_rd_addr;
  logic [LEN_WIDTH-1:0]   desc_rd_data;

  logic                   mem_rd_en;
  logic [DWIDTH-1:0]      mem_rd_addr;
  logic [DWIDTH-1:0]      mem_rd_data;

  logic                   tx_valid;
  logic                   tx_ready;
  logic [DWIDTH-1:0]      tx_data;
  logic                   tx_last;
  logic [PRIOR_WIDTH-1:0] tx_prior;

  modport master (
    input  sche_valid, sche_data, sche_prior,
    output sche_deque_en,
    output desc_rd_en, desc_rd_addr,
    input  desc_rd_data,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output tx_valid, tx_data, tx_last, tx_prior,
    input  tx_ready
  );

  modport slave (
    output sche_valid, sche_data, sche_prior,
    input  sche_deque_en,
    input  desc_rd_en, desc_rd_addr,
    output desc_rd_data,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  tx_valid, tx_data, tx_last, tx_prior,
    output tx_ready
  );
endinterface

// File: rtl/pkt_egress_tx.sv
// Packet egress transmitter: pops a scheduler entry, reads its length descriptor, then
// streams the payload one word per FETCH/LOAD/SEND round on a valid/ready port.
module pkt_egress_tx #(
  parameter int DWIDTH      = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int PRIOR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  pkt_egress_tx_if.master     bus,
  output logic [15:0]         pkt_count,
  output logic [15:0]         drop_count,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DESC  = 3'd1,
    DLEN  = 3'd2,
    FETCH = 3'd3,
    LOAD  = 3'd4,
    SEND  = 3'd5
  } state_t;

  state_t                 state;
  logic [DWIDTH-1:0]      base;
  logic [PRIOR_WIDTH-1:0] prio;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   idx;
  logic [DWIDTH-1:0]      tx_data_q;
  logic                   tx_last_q;
  logic [PRIOR_WIDTH-1:0] tx_prior_q;
  logic [15:0]            pkt_count_q;
  logic [15:0]            drop_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      base         <= '0;
      prio         <= '0;
      len          <= '0;
      idx          <= '0;
      tx_data_q    <= '0;
      tx_last_q    <= 1'b0;
      tx_prior_q   <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sche_valid) begin
            base  <= bus.sche_data;
            prio  <= bus.sche_prior;
            state <= DESC;
          end
        end
        DESC: state <= DLEN;
        DLEN: begin
          len <= bus.desc_rd_data;
          idx <= '0;
          // Zero-length packets are counted and discarded without touching the stream.
          if (bus.desc_rd_data == '0) begin
            drop_count_q <= drop_count_q + 16'd1;
            state        <= IDLE;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          tx_data_q  <= bus.mem_rd_data;
          tx_last_q  <= (idx == len - LEN_WIDTH'(1));
          tx_prior_q <= prio;
          state      <= SEND;
        end
        SEND: begin
          if (bus.tx_ready) begin
            if (tx_last_q) begin
              pkt_count_q <= pkt_count_q + 16'd1;
              state       <= IDLE;
            end else begin
              idx   <= idx + LEN_WIDTH'(1);
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held, including the cycle reset first asserts.
  assign bus.sche_deque_en = rst && (state == IDLE) && bus.sche_valid;
  assign bus.desc_rd_en    = rst && (state == DESC);
  assign bus.desc_rd_addr  = bus.desc_rd_en ? base : '0;
  assign bus.mem_rd_en     = rst && (state == FETCH);
  assign bus.mem_rd_addr   = bus.mem_rd_en ? (base + DWIDTH'(idx)) : '0;
  assign bus.tx_valid      = rst && (state == SEND);
  assign bus.tx_data       = rst ? tx_data_q : '0;
  assign bus.tx_last       = rst && tx_last_q;
  assign bus.tx_prior      = rst ? tx_prior_q : '0;
  assign pkt_count         = rst ? pkt_count_q : '0;
  assign drop_count        = rst ? drop_count_q : '0;
  assign state_dbg         = rst ? state : IDLE;

endmodule

// File: tb/tb_pkt_egress_tx.sv
// Directed bench for pkt_egress_tx with descriptor/payload responders and a scoreboard
// of expected read addresses and egress words.
module tb_pkt_egress_tx;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int PW = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_egress_tx_if #(.DWIDTH(DW), .LEN_WIDTH(LW), .PRIOR_WIDTH(PW)) bus ();
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic [2:0]  state_dbg;

  pkt_egress_tx #(.DWIDTH(DW), .LEN_WIDTH(LW), .PRIOR_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int deque_cnt = 0, desc_cnt = 0, mem_cnt = 0, txv_cnt = 0, hs_cnt = 0;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [0:0]    exp_last_q[$];
  logic [PW-1:0] exp_prior_q[$];
  logic [DW-1:0] exp_addr_q[$];
  logic [LW-1:0] desc_mem [logic [DW-1:0]];

  function automatic logic [DW-1:0] payload(input logic [DW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.sche_deque_en, bus.desc_rd_en, bus.desc_rd_addr, bus.mem_rd_en,
             bus.mem_rd_addr, bus.tx_valid, bus.tx_data, bus.tx_last, bus.tx_prior,
             pkt_count, drop_count, state_dbg};
  endfunction

  // descriptor and payload memories answer one cycle after the strobe
  always @(posedge clk) begin
    if (bus.desc_rd_en)
      bus.desc_rd_data <= desc_mem.exists(bus.desc_rd_addr) ? desc_mem[bus.desc_rd_addr] : '0;
    if (bus.mem_rd_en)
      bus.mem_rd_data <= payload(bus.mem_rd_addr);
  end

  // monitor: event counts plus scoreboard pops
  always @(negedge clk) begin
    if (rst) begin
      if (bus.sche_deque_en) deque_cnt++;
      if (bus.desc_rd_en)    desc_cnt++;
      if (bus.tx_valid)      txv_cnt++;
      if (bus.mem_rd_en) begin
        mem_cnt++;
        if (exp_addr_q.size() == 0) check("mem_rd_unexpected", bus.mem_rd_en, 0);
        else check("mem_rd_addr", bus.mem_rd_addr, exp_addr_q.pop_front());
      end
      if (bus.tx_valid && bus.tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("tx_unexpected_word", bus.tx_valid, 0);
        else begin
          check("tx_data",  bus.tx_data,  exp_q.pop_front());
          check("tx_last",  bus.tx_last,  exp_last_q.pop_front());
          check("tx_prior", bus.tx_prior, exp_prior_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push_pkt(input logic [DW-1:0] b, input logic [LW-1:0] len, input logic [PW-1:0] pr);
    desc_mem[b] = len;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr_q.push_back(b + DW'(i));
      exp_q.push_back(payload(b + DW'(i)));
      exp_last_q.push_back(i == int'(len) - 1);
      exp_prior_q.push_back(pr);
    end
  endtask

  task automatic drive_entry(input logic [DW-1:0] b, input logic [PW-1:0] pr);
    bus.sche_valid = 1'b1;
    bus.sche_data  = b;
    bus.sche_prior = pr;
  endtask

  task automatic wait_pkts(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (pkt_count !== target && n < budget) begin
      next();
      samp();
      n++;
    end
    check(tag, pkt_count, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, m0, v0, d0, n;
    bus.sche_valid = 1'b0;
    bus.sche_data  = '0;
    bus.sche_prior = '0;
    bus.tx_ready   = 1'b1;
    rst = 1'b0;
    repeat (3) next();
    samp();
    check("reset_outputs_zero", any_out(), 0);
    next(); rst = 1'b1; samp();
    check("idle_no_deque", bus.sche_deque_en, 0);

    // packet of 3 words at 0x100, latency and throughput
    push_pkt(32'h100, 3, 5);
    next(); drive_entry(32'h100, 5); samp(); t0 = cyc;
    check("t1_deque", bus.sche_deque_en, 1);
    next(); bus.sche_valid = 1'b0; samp();
    check("t1_desc_en", bus.desc_rd_en, 1);
    check("t1_desc_addr", bus.desc_rd_addr, 32'h100);
    check("t1_no_deque_T1", bus.sche_deque_en, 0);
    next(); samp(); check("t1_no_mem_T2", bus.mem_rd_en, 0);
    next(); samp(); check("t1_mem_en_T3", bus.mem_rd_en, 1);
    next(); samp(); check("t1_no_valid_T4", bus.tx_valid, 0);
    next(); samp(); check("t1_valid_T5", bus.tx_valid, 1);
    wait_pkts(16'd1, 40, "t1_pkt_count");
    check("t1_done_cycle", cyc - t0, 12);
    check("t1_deque_cnt", deque_cnt, 1);
    check("t1_desc_cnt", desc_cnt, 1);
    check("t1_mem_cnt", mem_cnt, 3);
    check("t1_hs_cnt", hs_cnt, 3);

    // backpressure on word 2
    push_pkt(32'h200, 3, 7);
    next(); drive_entry(32'h200, 7); samp(); t0 = cyc;
    check("t2_deque", bus.sche_deque_en, 1);
    next(); bus.sche_valid = 1'b0; samp();
    repeat (4) begin next(); samp(); end
    check("t2_word1_T5", bus.tx_valid, 1);
    next(); samp();
    next(); samp();
    next(); bus.tx_ready = 1'b0; samp();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin next(); samp(); end
      check("t2_stall_valid", bus.tx_valid, 1);
      check("t2_stall_data", bus.tx_data, payload(32'h201));
      check("t2_stall_last", bus.tx_last, 0);
      check("t2_stall_prior", bus.tx_prior, 7);
      check("t2_stall_no_mem", bus.mem_rd_en, 0);
    end
    next(); bus.tx_ready = 1'b1; samp();
    check("t2_hs_T13", bus.tx_valid, 1);
    next(); samp();
    check("t2_mem_T14", bus.mem_rd_en, 1);
    check("t2_novalid_T14", bus.tx_valid, 0);
    next(); samp(); check("t2_novalid_T15", bus.tx_valid, 0);
    next(); samp();
    check("t2_word3_T16", bus.tx_valid, 1);
    check("t2_word3_last", bus.tx_last, 1);
    check("t2_cycle", cyc - t0, 16);
    wait_pkts(16'd2, 20, "t2_pkt_count");

    // zero-length packet, then wrap-around addresses
    push_pkt(32'h300, 0, 1);
    m0 = mem_cnt; v0 = txv_cnt;
    next(); drive_entry(32'h300, 1); samp();
    check("t3_deque", bus.sche_deque_en, 1);
    next(); bus.sche_valid = 1'b0; samp();
    next(); samp(); check("t3_drop_T2", drop_count, 0);
    push_pkt(32'hFFFF_FFFF, 2, 3);
    next(); drive_entry(32'hFFFF_FFFF, 3); samp();
    check("t3_idle_T3", bus.sche_deque_en, 1);
    check("t3_drop_T3", drop_count, 1);
    check("t3_no_mem", mem_cnt, m0);
    check("t3_no_valid", txv_cnt, v0);
    next(); bus.sche_valid = 1'b0; samp();
    wait_pkts(16'd3, 30, "t4_pkt_count");
    check("t4_mem_cnt", mem_cnt - m0, 2);

    // two queued entries, back to back
    push_pkt(32'h400, 2, 5);
    push_pkt(32'h500, 1, 9);
    d0 = deque_cnt;
    next(); drive_entry(32'h400, 5); samp(); t0 = cyc;
    check("t5_deque1", bus.sche_deque_en, 1);
    next(); drive_entry(32'h500, 9); samp();
    check("t5_no_deque_T1", bus.sche_deque_en, 0);
    n = 0;
    while (bus.sche_deque_en !== 1'b1 && n < 30) begin next(); samp(); n++; end
    check("t5_deque2_cycle", cyc - t0, 9);
    next(); bus.sche_valid = 1'b0; samp();
    wait_pkts(16'd5, 30, "t5_pkt_count");
    check("t5_deque_cnt", deque_cnt - d0, 2);

    // reset in SEND of word 2, then immediate restart
    push_pkt(32'h600, 3, 2);
    next(); drive_entry(32'h600, 2); samp();
    next(); bus.sche_valid = 1'b0; samp();
    repeat (6) begin next(); samp(); end
    next(); bus.tx_ready = 1'b0; samp();
    check("t6_word2_valid", bus.tx_valid, 1);
    next(); rst = 1'b0; samp();
    check("t6_rst_outputs_zero", any_out(), 0);
    exp_q.delete(); exp_last_q.delete(); exp_prior_q.delete(); exp_addr_q.delete();
    next(); samp();
    check("t6_rst_outputs_zero2", any_out(), 0);
    push_pkt(32'h700, 1, 4);
    next(); rst = 1'b1; bus.tx_ready = 1'b1; drive_entry(32'h700, 4); samp();
    check("t6_deque_first_cycle", bus.sche_deque_en, 1);
    check("t6_pkt_count_cleared", pkt_count, 0);
    next(); bus.sche_valid = 1'b0; samp();
    wait_pkts(16'd1, 20, "t6_pkt_count");
    check("t6_drop_count", drop_count, 0);

    next(); samp();
    check("sb_words_drained", exp_q.size(), 0);
    check("sb_addrs_drained", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
